// File: rtl/me_bank_pkg.sv
// Shared constants and word types for the motion-estimation reference banks.
package me_bank_pkg;

  localparam int PIXEL = 8;
  localparam int LANES = 8;
  localparam int W     = PIXEL * LANES;
  localparam int DEPTH = 96;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [PIXEL-1:0] pixel_t;
  typedef logic [W-1:0]     ref_word_t;

  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return addr < AW'(DEPTH);
  endfunction

endpackage

// File: rtl/ref_bank_if.sv
// Fill/read bus of a reference bank; master drives stimulus, slave is the bank.
interface ref_bank_if;
  import me_bank_pkg::*;

  logic            beg_en;
  ref_word_t       ref_in;
  logic            Bank_sel;
  logic [AW-1:0]   address;
  logic            rd_en;
  ref_word_t       ref_ou;

  modport master (
    output beg_en, ref_in, Bank_sel, address, rd_en,
    input  ref_ou
  );

  modport slave (
    input  beg_en, ref_in, Bank_sel, address, rd_en,
    output ref_ou
  );

endinterface

// File: rtl/bank_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with enable,
// read-before-write on a same-address collision.
module bank_dpram
  import me_bank_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ref_word_t     wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output ref_word_t     rdata_o
);

  // NOTE: the array has no reset so it maps onto block RAM; contents are X until written.
  ref_word_t mem_q [DEPTH];
  ref_word_t rdata_q;

  // NOTE: non-blocking assignments make the read sample the pre-write contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ref_bank.sv
// Reference-pixel bank: sequential fill on port B, registered random read on port A.
// Define BANK_WRAP_EN for circular fill; default saturates the write pointer at DEPTH.
module ref_bank
  import me_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ref_bank_if.slave  bus
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_req;
  logic          ram_we;
  logic          ram_re;
  logic          rd_in_range;
  logic          zero_q;
  ref_word_t     ram_q;

`ifdef BANK_WRAP_EN
  assign wr_req = bus.beg_en && !bus.Bank_sel;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(1);
    if (wr_ptr_q == AW'(DEPTH - 1)) wr_ptr_d = '0;
  end
`else
  // Pointer parks at DEPTH once the bank is full, which also blocks further writes.
  assign wr_req = bus.beg_en && !bus.Bank_sel && (wr_ptr_q != AW'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(1);
  end
`endif

  assign rd_in_range = addr_in_range(bus.address);
  assign ram_we      = rst_n && wr_req;
  assign ram_re      = rst_n && !bus.rd_en && rd_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      if (wr_req)      wr_ptr_q <= wr_ptr_d;
      if (!bus.rd_en)  zero_q   <= !rd_in_range;
    end
  end

  bank_dpram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.ref_in),
    .re_i    (ram_re),
    .raddr_i (bus.address),
    .rdata_o (ram_q)
  );

  // Reset and out-of-range reads force zero without touching the RAM's output register.
  assign bus.ref_ou = zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_ref_bank.sv
// Directed self-checking bench for ref_bank; expectations follow BANK_WRAP_EN.
module tb_ref_bank;
  import me_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  ref_bank_if bus ();

  ref_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam ref_word_t P0F  = {8{8'h0F}};
  localparam ref_word_t P55  = {8{8'h55}};
  localparam ref_word_t P33  = {8{8'h33}};
  localparam ref_word_t P77  = {8{8'h77}};
  localparam ref_word_t PAA  = {8{8'hAA}};
  localparam ref_word_t ONES = '1;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic ref_word_t count_word(input int k);
    return ref_word_t'(64'hC0DE_0000_0000_0000) | ref_word_t'(k);
  endfunction

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.beg_en   = 1'b1;
    bus.ref_in   = ONES;
    bus.Bank_sel = 1'b0;
    bus.address  = '0;
    bus.rd_en    = 1'b1;
    cycle();
    n_total++;
    if (bus.ref_ou !== '0)
      $display("FAIL reset_ref_ou got=%h exp=%h", bus.ref_ou, ref_word_t'(0));
    else n_pass++;
    rst_n      = 1'b1;
    bus.beg_en = 1'b0;
  endtask

  task automatic test_fill();
    bus.Bank_sel = 1'b0;
    bus.beg_en   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ref_in = (i < 3) ? P0F : (i < 6) ? P55 : P33;
      cycle();
    end
    bus.beg_en = 1'b0;
  endtask

  task automatic test_readback();
    logic [AW-1:0] addrs [7] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd8};
    ref_word_t     exps  [7] = '{P0F, P0F, P0F, P55, P55, P55, P33};
    bus.rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.address = addrs[i];
      cycle();
      n_total++;
      if (bus.ref_ou !== exps[i])
        $display("FAIL readback addr=%0d got=%h exp=%h", addrs[i], bus.ref_ou, exps[i]);
      else n_pass++;
    end
    bus.rd_en = 1'b1;
  endtask

  task automatic test_write_block();
    logic [AW-1:0] addrs [4] = '{7'd0, 7'd5, 7'd15, 7'd16};
    ref_word_t     exps  [4] = '{P0F, P55, P33, P77};
    bus.Bank_sel = 1'b1;
    bus.beg_en   = 1'b1;
    bus.ref_in   = ONES;
    repeat (4) cycle();
    // A single fill-mode write must land at 16 if the pointer held.
    bus.Bank_sel = 1'b0;
    bus.ref_in   = P77;
    cycle();
    bus.beg_en = 1'b0;
    bus.rd_en  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.address = addrs[i];
      cycle();
      n_total++;
      if (bus.ref_ou !== exps[i])
        $display("FAIL block addr=%0d got=%h exp=%h", addrs[i], bus.ref_ou, exps[i]);
      else n_pass++;
    end
    bus.address = 7'd2;
    cycle();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.address = (i == 0) ? 7'd5 : 7'd10;
      cycle();
      n_total++;
      if (bus.ref_ou !== P0F)
        $display("FAIL rd_hold step=%0d got=%h exp=%h", i, bus.ref_ou, P0F);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] addrs [3] = '{7'd96, 7'd0, 7'd127};
    ref_word_t     exps  [3] = '{'0, P0F, '0};
    bus.rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.address = addrs[i];
      cycle();
      n_total++;
      if (bus.ref_ou !== exps[i])
        $display("FAIL range addr=%0d got=%h exp=%h", addrs[i], bus.ref_ou, exps[i]);
      else n_pass++;
    end
    bus.rd_en = 1'b1;
  endtask

  task automatic test_collision_after_reset();
    logic [AW-1:0] addrs [2] = '{7'd0, 7'd1};
    ref_word_t     exps  [2] = '{PAA, P0F};
    // Reset with a pending write and read: output clears, memory untouched.
    rst_n       = 1'b0;
    bus.beg_en  = 1'b1;
    bus.ref_in  = ONES;
    bus.rd_en   = 1'b0;
    bus.address = 7'd3;
    cycle();
    n_total++;
    if (bus.ref_ou !== '0)
      $display("FAIL reset_read got=%h exp=%h", bus.ref_ou, ref_word_t'(0));
    else n_pass++;
    rst_n       = 1'b1;
    bus.ref_in  = PAA;
    bus.address = 7'd0;
    cycle();
    n_total++;
    if (bus.ref_ou !== P0F)
      $display("FAIL collision_old got=%h exp=%h", bus.ref_ou, P0F);
    else n_pass++;
    bus.beg_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.address = addrs[i];
      cycle();
      n_total++;
      if (bus.ref_ou !== exps[i])
        $display("FAIL refill addr=%0d got=%h exp=%h", addrs[i], bus.ref_ou, exps[i]);
      else n_pass++;
    end
    bus.rd_en = 1'b1;
  endtask

  task automatic test_full_fill();
    logic [AW-1:0] addrs [7] = '{7'd0, 7'd1, 7'd3, 7'd4, 7'd50, 7'd94, 7'd95};
    ref_word_t     exp_w;
    rst_n      = 1'b0;
    bus.beg_en = 1'b0;
    cycle();
    rst_n      = 1'b1;
    bus.beg_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      bus.ref_in = count_word(k);
      cycle();
    end
    bus.beg_en = 1'b0;
    bus.rd_en  = 1'b0;
    for (int i = 0; i < 7; i++) begin
`ifdef BANK_WRAP_EN
      exp_w = (addrs[i] < 4) ? count_word(int'(addrs[i]) + 97) : count_word(int'(addrs[i]) + 1);
`else
      exp_w = count_word(int'(addrs[i]) + 1);
`endif
      bus.address = addrs[i];
      cycle();
      n_total++;
      if (bus.ref_ou !== exp_w)
        $display("FAIL full_fill addr=%0d got=%h exp=%h", addrs[i], bus.ref_ou, exp_w);
      else n_pass++;
    end
    bus.rd_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_readback();
    test_write_block();
    test_out_of_range();
    test_collision_after_reset();
    test_full_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
